// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-way round-robin arbiter with registered one-hot grant
// Rotating-priority search from ptr; the winner's successor becomes the new highest priority.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         valid_grant
);

    localparam int PW = (N > 2) ? $clog2(N) : 1;
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    logic [PW-1:0] ptr;
    logic [N-1:0]  mask;
    logic [N-1:0]  masked;
    logic [PW-1:0] win_masked;
    logic [PW-1:0] win_any;
    logic [PW-1:0] win;
    logic [PW-1:0] ptr_next;
    logic [N-1:0]  grant_next;

    // Thermometer mask keeps indices at or above ptr; fallback covers the wrap part.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (PW'(i) >= ptr);
        end
        masked = req & mask;
    end

    always_comb begin
        win_masked = '0;
        win_any    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (masked[i]) begin
                win_masked = PW'(i);
            end
            if (req[i]) begin
                win_any = PW'(i);
            end
        end
        win = (|masked) ? win_masked : win_any;
    end

    always_comb begin
        grant_next = '0;
        for (int i = 0; i < N; i++) begin
            grant_next[i] = (PW'(i) == win) && (|req);
        end
        ptr_next = (win == LAST) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            grant       <= '0;
            valid_grant <= 1'b0;
            ptr         <= '0;
        end else if (|req) begin
            grant       <= grant_next;
            valid_grant <= 1'b1;
            ptr         <= ptr_next;
        end else begin
            grant       <= '0;
            valid_grant <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - scoreboard bench for rr_arbiter at N=4 and N=3
module tb_rr_arbiter;

    typedef struct {
        logic [3:0] g;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst4 = 1'b0;
    logic       rst3 = 1'b0;
    logic [3:0] req4 = 4'b0000;
    logic [2:0] req3 = 3'b000;
    logic [3:0] grant4;
    logic [2:0] grant3;
    logic       vg4;
    logic       vg3;

    int checks = 0;
    int errors = 0;

    exp_t q4[$];
    exp_t q3[$];

    rr_arbiter #(.N(4)) dut4 (
        .clk(clk), .reset(rst4), .req(req4), .grant(grant4), .valid_grant(vg4)
    );

    rr_arbiter #(.N(3)) dut3 (
        .clk(clk), .reset(rst3), .req(req3), .grant(grant3), .valid_grant(vg3)
    );

    always #5 clk = ~clk;

    task automatic step4(input logic rst, input logic [3:0] r, input logic [3:0] eg, input string nm);
        exp_t e;
        @(negedge clk);
        rst4 = rst;
        req4 = r;
        e.g = eg;
        e.name = nm;
        q4.push_back(e);
    endtask

    task automatic step3(input logic rst, input logic [2:0] r, input logic [2:0] eg, input string nm);
        exp_t e;
        @(negedge clk);
        rst3 = rst;
        req3 = r;
        e.g = {1'b0, eg};
        e.name = nm;
        q3.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        logic ev;
        #1;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            ev = (e.g != 4'b0000);
            checks++;
            if (grant4 !== e.g) begin
                errors++;
                $display("FAIL n4 %s grant got %b want %b", e.name, grant4, e.g);
            end
            checks++;
            if (vg4 !== ev) begin
                errors++;
                $display("FAIL n4 %s valid_grant got %b want %b", e.name, vg4, ev);
            end
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            ev = (e.g != 4'b0000);
            checks++;
            if (grant3 !== e.g[2:0]) begin
                errors++;
                $display("FAIL n3 %s grant got %b want %b", e.name, grant3, e.g[2:0]);
            end
            checks++;
            if (vg3 !== ev) begin
                errors++;
                $display("FAIL n3 %s valid_grant got %b want %b", e.name, vg3, ev);
            end
        end
    end

    initial begin
        step4(1'b0, 4'b1111, 4'b0000, "rst_a");
        step4(1'b0, 4'b1111, 4'b0000, "rst_b");
        step4(1'b1, 4'b0000, 4'b0000, "idle_after_rst");
        step4(1'b1, 4'b1000, 4'b1000, "single3_a");
        step4(1'b1, 4'b1000, 4'b1000, "single3_b");
        step4(1'b1, 4'b0001, 4'b0001, "after_wrap");

        step4(1'b0, 4'b0000, 4'b0000, "rst_fair");
        step4(1'b1, 4'b1111, 4'b0001, "fair_0");
        step4(1'b1, 4'b1111, 4'b0010, "fair_1");
        step4(1'b1, 4'b1111, 4'b0100, "fair_2");
        step4(1'b1, 4'b1111, 4'b1000, "fair_3");
        step4(1'b1, 4'b1111, 4'b0001, "fair_4");

        step4(1'b0, 4'b0000, 4'b0000, "rst_alt");
        step4(1'b1, 4'b1001, 4'b0001, "alt_0");
        step4(1'b1, 4'b1001, 4'b1000, "alt_1");
        step4(1'b1, 4'b1001, 4'b0001, "alt_2");
        step4(1'b1, 4'b0110, 4'b0010, "alt_3");
        step4(1'b1, 4'b0110, 4'b0100, "alt_4");

        step4(1'b0, 4'b0000, 4'b0000, "rst_wrap");
        step4(1'b1, 4'b0100, 4'b0100, "wrap_set_ptr3");
        step4(1'b1, 4'b0011, 4'b0001, "wrap_search");
        step4(1'b1, 4'b0000, 4'b0000, "wrap_idle");
        step4(1'b1, 4'b0011, 4'b0010, "wrap_ptr_held");
        step4(1'b1, 4'b0010, 4'b0010, "lone_a");
        step4(1'b1, 4'b0010, 4'b0010, "lone_b");
        step4(1'b0, 4'b1111, 4'b0000, "midop_rst");
        step4(1'b1, 4'b1111, 4'b0001, "post_rst");

        step3(1'b0, 3'b000, 3'b000, "rst");
        rst4 = 1'b0;
        step3(1'b1, 3'b111, 3'b001, "cyc_0");
        step3(1'b1, 3'b111, 3'b010, "cyc_1");
        step3(1'b1, 3'b111, 3'b100, "cyc_2");
        step3(1'b1, 3'b111, 3'b001, "cyc_3");
        step3(1'b1, 3'b111, 3'b010, "cyc_4");
        step3(1'b0, 3'b111, 3'b000, "midop_rst");
        step3(1'b1, 3'b111, 3'b001, "re_0");
        step3(1'b1, 3'b111, 3'b010, "re_1");
        step3(1'b1, 3'b111, 3'b100, "re_2");
        step3(1'b1, 3'b111, 3'b001, "re_3");
        step3(1'b1, 3'b101, 3'b100, "skip_1");
        step3(1'b1, 3'b000, 3'b000, "idle");

        for (int i = 0; i < 10; i++) begin
            if (q4.size() == 0 && q3.size() == 0) break;
            @(posedge clk);
        end
        #3;
        if (q4.size() != 0 || q3.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending got %0d want 0", q4.size() + q3.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
